// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin/lockable arbiter for the byte-wide memory bus with a watchdog.
// Grant 1 cycle after request; the loser holds its request (ready=0) until the owner completes or releases.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic                  m0_lock,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ready,
   output logic                  m0_err,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ready,
   output logic                  m1_err,
   output logic                  s_read,
   output logic                  s_write,
   output logic [ADDR_WIDTH-1:0] s_addr,
   output logic [DATA_WIDTH-1:0] s_wdata,
   input  logic [DATA_WIDTH-1:0] s_rdata,
   input  logic                  s_ready,
   output logic [1:0]            grant
);

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;

   state_t                  state_q, state_d;
   logic                    last_q, last_d;
   logic [15:0]             wcnt_q, wcnt_d;

   logic                    req0, req1;
   logic                    own, own_read, own_write, own_lock, own_req;
   logic [ADDR_WIDTH-1:0]   own_addr;
   logic [DATA_WIDTH-1:0]   own_wdata;
   logic                    granted, tmo;

   assign req0    = m0_read | m0_write;
   assign req1    = m1_read | m1_write;
   assign granted = (state_q != IDLE);
   assign tmo     = granted && (wcnt_q == TMO);

   always_comb begin
      own       = (state_q == G1);
      own_read  = own ? m1_read  : m0_read;
      own_write = own ? m1_write : m0_write;
      own_lock  = own ? m1_lock  : m0_lock;
      own_addr  = own ? m1_addr  : m0_addr;
      own_wdata = own ? m1_wdata : m0_wdata;
      own_req   = own_read | own_write;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         IDLE: begin
            wcnt_d = '0;
            if (req0 && req1)  state_d = last_q ? G0 : G1;
            else if (req0)     state_d = G0;
            else if (req1)     state_d = G1;
         end
         G0, G1: begin
            // Watchdog wins over everything, including a late s_ready and the lock.
            if (tmo) begin
               state_d = IDLE;
               last_d  = own;
               wcnt_d  = '0;
            end else if (own_req && s_ready) begin
               last_d  = own;
               wcnt_d  = '0;
               state_d = own_lock ? state_q : IDLE;
            end else if (!own_req && !own_lock) begin
               state_d = IDLE;
               last_d  = own;
               wcnt_d  = '0;
            end else if (own_req) begin
               wcnt_d  = 16'(wcnt_q + 16'd1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_read   = 1'b0;
      s_write  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = '0;
      m1_rdata = '0;
      m0_err   = 1'b0;
      m1_err   = 1'b0;
      grant    = state_q;
      if (granted) begin
         s_read  = own_read & ~own_write;
         s_write = own_write;
         if (own_req) begin
            s_addr  = own_addr;
            s_wdata = own_wdata;
         end
         if (own) begin
            m1_ready = s_ready | tmo;
            m1_rdata = tmo ? '0 : s_rdata;
            m1_err   = tmo;
         end else begin
            m0_ready = s_ready | tmo;
            m0_rdata = tmo ? '0 : s_rdata;
            m0_err   = tmo;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: reference table, directed corner sequences and randomized traffic vs a model.
module tb_mem_bus_arbiter;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  rd = '0, wr = '0, lk = '0;
   logic [31:0] ad [2];
   logic [7:0]  wd [2];
   logic [7:0]  s_rdata = 8'h5A;
   logic        s_ready = 1'b0;

   logic [7:0]  m0_rdata, m1_rdata, s_wdata;
   logic        m0_ready, m0_err, m1_ready, m1_err, s_read, s_write;
   logic [31:0] s_addr;
   logic [1:0]  grant;
   logic [63:0] dut_vec;

   int n_checks = 0;
   int n_errors = 0;

   int m_owner, m_last, m_wait;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst_n),
      .m0_read(rd[0]), .m0_write(wr[0]), .m0_lock(lk[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_read(rd[1]), .m1_write(wr[1]), .m1_lock(lk[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
      .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant)
   );

   assign dut_vec = {grant, s_read, s_write, s_addr, s_wdata,
                     m0_ready, m0_err, m0_rdata, m1_ready, m1_err, m1_rdata};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 1;
      m_wait  = 0;
   endtask

   // Expected outputs for the current owner and the inputs presented this cycle.
   function automatic logic [63:0] model_out();
      logic [1:0]  g = '0, rdy = '0, er = '0;
      logic        sr = 1'b0, sw = 1'b0;
      logic [31:0] sa = '0;
      logic [7:0]  swd = '0, d0 = '0, d1 = '0, dv;
      bit          req, tm;
      int          n;
      if (m_owner >= 0) begin
         n      = m_owner;
         req    = rd[n] | wr[n];
         tm     = (m_wait == TIMEOUT);
         g[n]   = 1'b1;
         sr     = rd[n] & ~wr[n];
         sw     = wr[n];
         if (req) begin
            sa  = ad[n];
            swd = wd[n];
         end
         rdy[n] = s_ready | tm;
         er[n]  = tm;
         dv     = tm ? 8'h00 : s_rdata;
         if (n == 0) d0 = dv; else d1 = dv;
      end
      return {g, sr, sw, sa, swd, rdy[0], er[0], d0, rdy[1], er[1], d1};
   endfunction

   // Ownership rules applied at each rising edge.
   task automatic model_edge();
      int  n;
      bit  req;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_owner < 0) begin
         if ((rd[0] | wr[0]) && (rd[1] | wr[1])) m_owner = 1 - m_last;
         else if (rd[0] | wr[0])                 m_owner = 0;
         else if (rd[1] | wr[1])                 m_owner = 1;
         m_wait = 0;
      end else begin
         n   = m_owner;
         req = rd[n] | wr[n];
         if (m_wait == TIMEOUT || (!req && !lk[n])) begin
            m_owner = -1; m_last = n; m_wait = 0;
         end else if (req && s_ready) begin
            m_last = n; m_wait = 0;
            if (!lk[n]) m_owner = -1;
         end else if (req) begin
            m_wait++;
         end
      end
   endtask

   task automatic settle();
      #2;
      check("model", dut_vec, model_out());
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic        r0, r1, srdy;
      logic [31:0] a0, a1;
      logic [1:0]  eg;
      logic        er0, er1;
      logic [31:0] esa;
   } vec_t;

   function automatic vec_t mkv(logic r0, logic r1, logic srdy, logic [31:0] a0, logic [31:0] a1,
                                logic [1:0] eg, logic er0, logic er1, logic [31:0] esa);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.srdy = srdy; v.a0 = a0; v.a1 = a1;
      v.eg = eg; v.er0 = er0; v.er1 = er1; v.esa = esa;
      return v;
   endfunction

   initial begin
      vec_t tbl [13];
      int   comps, gcnt, err_at, p;
      bit   seen;

      ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
      model_reset();

      // Both read together; m0 served first, IDLE gap, then m1; ready in IDLE ignored.
      tbl[0]  = mkv(1, 1, 0, 32'h0, 32'h2000, 2'b00, 0, 0, 32'h0);
      for (int i = 1; i <= 4; i++) tbl[i] = mkv(1, 1, 0, 32'h0, 32'h2000, 2'b01, 0, 0, 32'h0);
      tbl[5]  = mkv(1, 1, 1, 32'h0, 32'h2000, 2'b01, 1, 0, 32'h0);
      tbl[6]  = mkv(0, 1, 0, 32'h0, 32'h2000, 2'b00, 0, 0, 32'h0);
      for (int i = 7; i <= 10; i++) tbl[i] = mkv(0, 1, 0, 32'h0, 32'h2000, 2'b10, 0, 0, 32'h2000);
      tbl[11] = mkv(0, 1, 1, 32'h0, 32'h2000, 2'b10, 0, 1, 32'h2000);
      tbl[12] = mkv(0, 0, 1, 32'h0, 32'h2000, 2'b00, 0, 0, 32'h0);

      settle();
      check("reset_grant", grant, 2'b00);
      check("reset_ready", {m0_ready, m1_ready, m0_err, m1_err}, 4'b0);
      advance();
      advance();
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         rd = {tbl[i].r1, tbl[i].r0}; wr = '0; lk = '0;
         ad[0] = tbl[i].a0; ad[1] = tbl[i].a1; s_ready = tbl[i].srdy;
         settle();
         check("tbl_grant", grant, tbl[i].eg);
         check("tbl_ready", {m0_ready, m1_ready}, {tbl[i].er0, tbl[i].er1});
         check("tbl_saddr", s_addr, tbl[i].esa);
         advance();
      end

      // Continuous requests from both: grants alternate, nothing lost.
      rd = 2'b11; s_ready = 1'b1; ad[0] = 32'h100; ad[1] = 32'h200;
      comps = 0;
      for (int c = 0; c < 30 && comps < 6; c++) begin
         settle();
         if (m0_ready || m1_ready) begin
            check("alt_grant", grant, (comps % 2 == 0) ? 2'b01 : 2'b10);
            comps++;
         end
         advance();
      end
      check("alt_count", comps, 6);
      rd = '0; s_ready = 1'b0;
      settle(); advance();

      // m1 locks for four ACC writes while m0 waits.
      wr = 2'b10; lk = 2'b10; ad[1] = 32'h3000;
      settle(); advance();
      rd[0] = 1'b1; ad[0] = 32'h40;
      for (int k = 0; k < 4; k++) begin
         ad[1] = 32'h3000 + k; wd[1] = 8'(k + 1); s_ready = 1'b0;
         settle();
         check("lock_grant_wait", grant, 2'b10);
         advance();
         s_ready = 1'b1;
         settle();
         check("lock_grant_done", {grant, m0_ready, m1_ready, s_addr}, {2'b10, 1'b0, 1'b1, 32'h3000 + k});
         advance();
      end
      wr = '0; lk = '0; s_ready = 1'b0;
      settle(); check("unlock_hold", grant, 2'b10); advance();
      settle(); check("unlock_idle", grant, 2'b00); advance();
      settle(); check("unlock_m0", grant, 2'b01);
      s_ready = 1'b1; settle(); advance();
      rd = '0; s_ready = 1'b0; settle(); advance();

      // Watchdog on an unmapped read.
      rd[0] = 1'b1; ad[0] = 32'hDEAD_0000; s_rdata = 8'hA5;
      gcnt = 0; err_at = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         settle();
         if (grant == 2'b01) gcnt++;
         if (m0_err) begin
            seen = 1; err_at = gcnt;
            check("tmo_ready_rdata", {m0_ready, m0_rdata}, {1'b1, 8'h00});
         end
         advance();
      end
      check("tmo_cycle", err_at, 9);
      rd = '0;
      settle(); check("tmo_release", {grant, m0_err}, 3'b000); advance();

      // Asynchronous reset while a write waits.
      wr = 2'b01; ad[0] = 32'h1234; wd[0] = 8'h77;
      settle(); advance();
      settle(); check("rst_pre", {grant, s_write}, 3'b011);
      rst_n = 1'b0; s_ready = 1'b1;
      #1;
      check("rst_async", {grant, s_write, m0_ready}, 4'b0);
      model_reset();
      advance();
      settle(); advance();
      rst_n = 1'b1; wr = '0; rd = 2'b11; s_ready = 1'b0;
      settle(); advance();
      settle(); check("rst_m0_first", grant, 2'b01);
      s_ready = 1'b1; settle(); advance();
      rd = '0; s_ready = 1'b0; settle(); advance();

      // m1 withdraws before any ready.
      rd[1] = 1'b1; ad[1] = 32'h55;
      settle(); advance();
      for (int c = 0; c < 2; c++) begin
         settle(); check("wd_grant", {grant, m1_err}, 3'b100); advance();
      end
      rd = '0;
      settle(); check("wd_last", grant, 2'b10); advance();
      settle(); check("wd_idle", {grant, m1_err}, 3'b000); advance();

      // Randomized traffic against the model.
      for (int seg = 0; seg < 6; seg++) begin
         p = (seg % 3 == 0) ? 60 : (seg % 3 == 1) ? 25 : 5;
         for (int c = 0; c < 500; c++) begin
            for (int n = 0; n < 2; n++) begin
               rd[n] = ($urandom_range(0, 99) < 70);
               wr[n] = ($urandom_range(0, 99) < 30);
               lk[n] = ($urandom_range(0, 99) < 10);
               ad[n] = $urandom;
               wd[n] = 8'($urandom);
            end
            s_ready = ($urandom_range(0, 99) < p);
            s_rdata = 8'($urandom);
            settle();
            advance();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, time %0t limit 2000000", $time);
      $fatal(1, "bench timeout");
   end

endmodule
